// File: rtl/bram_shift_register_mc.sv
// ---------------------------------------------------------------------------
// bram_shift_register_mc
//   Multi-channel, BRAM-backed delay line with a runtime-programmable length.
//   A single-port read-first memory ring of `len` words (len <= DEPTH) holds
//   the in-flight samples; every lane occupies its own DATA_W slice of the
//   shared memory word.
//
// Ports
//   ap_clk      system clock, rising edge
//   reset_n     asynchronous active-low reset (synchronous release upstream)
//   shift_en    advance the line by one sample this cycle
//   shift_in    input sample, lane c at [c*DATA_W +: DATA_W]
//   len_in      requested delay length (clamped to 1..DEPTH)
//   len_load    one-cycle pulse, latches len_in and empties the line
//   flush       one-cycle pulse, empties the line, keeps the length
//   shift_out   registered delayed sample (0 while out_valid is low)
//   out_valid   shift_out holds a real delayed sample
//   fill_level  number of valid samples stored, 0..len
// ---------------------------------------------------------------------------
module bram_shift_register_mc #(
   parameter  int unsigned DEPTH    = 514,
   parameter  int unsigned DATA_W   = 8,
   parameter  int unsigned CHANNELS = 1,
   localparam int unsigned ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned LEN_W    = $clog2(DEPTH + 1)
) (
   input  logic                         ap_clk,
   input  logic                         reset_n,
   input  logic                         shift_en,
   input  logic [CHANNELS*DATA_W-1:0]   shift_in,
   input  logic [LEN_W-1:0]             len_in,
   input  logic                         len_load,
   input  logic                         flush,
   output logic [CHANNELS*DATA_W-1:0]   shift_out,
   output logic                         out_valid,
   output logic [LEN_W-1:0]             fill_level
);

   localparam int unsigned WORD_W = CHANNELS * DATA_W;

   logic [WORD_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] ptr;
   logic [LEN_W-1:0]  len;
   logic [LEN_W-1:0]  len_clamped;
   logic              do_shift;
   logic              at_len;
   logic              ptr_last;

   // A shift coincident with flush or len_load is dropped entirely, including
   // the memory write; reset_n gates the write so nothing lands during reset.
   always_comb begin
      do_shift = reset_n & shift_en & ~flush & ~len_load;
      at_len   = (fill_level == len);
      ptr_last = (LEN_W'(ptr) == (len - LEN_W'(1)));
      if (len_in == '0) begin
         len_clamped = LEN_W'(1);
      end else if (len_in > LEN_W'(DEPTH)) begin
         len_clamped = LEN_W'(DEPTH);
      end else begin
         len_clamped = len_in;
      end
   end

   // Memory array kept free of reset so it maps onto block RAM.
   always_ff @(posedge ap_clk) begin
      if (do_shift) begin
         mem[ptr] <= shift_in;
      end
   end

   always_ff @(posedge ap_clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr        <= '0;
         len        <= LEN_W'(DEPTH);
         fill_level <= '0;
         shift_out  <= '0;
         out_valid  <= 1'b0;
      end else if (flush) begin
         ptr        <= '0;
         fill_level <= '0;
         shift_out  <= '0;
         out_valid  <= 1'b0;
      end else if (len_load) begin
         len        <= len_clamped;
         ptr        <= '0;
         fill_level <= '0;
         shift_out  <= '0;
         out_valid  <= 1'b0;
      end else if (shift_en) begin
         // Read-first: the word leaving the ring is the sample written len
         // shifts ago, but only once the ring is full; before that the slot
         // holds stale data, so the output is forced to zero.
         shift_out  <= at_len ? mem[ptr] : '0;
         out_valid  <= at_len;
         fill_level <= at_len ? fill_level : fill_level + LEN_W'(1);
         ptr        <= ptr_last ? '0 : ptr + ADDR_W'(1);
      end
   end

endmodule

// File: tb/tb_bram_shift_register_mc.sv
module tb_bram_shift_register_mc;

   localparam int unsigned DEPTH = 514;
   localparam int unsigned LW    = 10;

   typedef struct {
      logic [7:0]    d;
      logic          v;
      logic [LW-1:0] f;
   } exp_t;

   logic          ap_clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          shift_en = 1'b0;
   logic [7:0]    shift_in = '0;
   logic [LW-1:0] len_in = '0;
   logic          len_load = 1'b0;
   logic          flush = 1'b0;
   logic [7:0]    shift_out;
   logic          out_valid;
   logic [LW-1:0] fill_level;

   logic          m_en = 1'b0;
   logic [23:0]   m_in = '0;
   logic [LW-1:0] m_len_in = '0;
   logic          m_load = 1'b0;
   logic          m_flush = 1'b0;
   logic [23:0]   m_out;
   logic          m_valid;
   logic [LW-1:0] m_fill;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   // scoreboard / reference model state (single-channel DUT)
   exp_t          exp_q[$];
   logic [7:0]    line_q[$];
   int unsigned   md_len = DEPTH;
   int unsigned   md_fill = 0;
   exp_t          last_exp = '{d: 8'h00, v: 1'b0, f: '0};

   always #5 ap_clk = ~ap_clk;

   bram_shift_register_mc #(.DEPTH(DEPTH), .DATA_W(8), .CHANNELS(1)) dut (
      .ap_clk(ap_clk), .reset_n(reset_n), .shift_en(shift_en),
      .shift_in(shift_in), .len_in(len_in), .len_load(len_load),
      .flush(flush), .shift_out(shift_out), .out_valid(out_valid),
      .fill_level(fill_level));

   bram_shift_register_mc #(.DEPTH(DEPTH), .DATA_W(8), .CHANNELS(3)) dut3 (
      .ap_clk(ap_clk), .reset_n(reset_n), .shift_en(m_en),
      .shift_in(m_in), .len_in(m_len_in), .len_load(m_load),
      .flush(m_flush), .shift_out(m_out), .out_valid(m_valid),
      .fill_level(m_fill));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic int unsigned clamp_len(input int unsigned li);
      if (li == 0) return 1;
      if (li > DEPTH) return DEPTH;
      return li;
   endfunction

   task automatic model_clear();
      line_q.delete();
      md_fill = 0;
      last_exp = '{d: 8'h00, v: 1'b0, f: '0};
   endtask

   // One clock of stimulus on the single-channel DUT; the model's expectation
   // is queued at drive time and compared once the edge has produced output.
   task automatic step(input logic en, input logic [7:0] d,
                       input logic fl = 1'b0, input logic ll = 1'b0,
                       input logic [LW-1:0] li = '0);
      exp_t e;
      shift_en = en; shift_in = d; flush = fl; len_load = ll; len_in = li;
      if (fl) begin
         model_clear();
      end else if (ll) begin
         md_len = clamp_len(int'(li));
         model_clear();
      end else if (en) begin
         if (md_fill == md_len) begin
            last_exp.d = line_q.pop_front();
            last_exp.v = 1'b1;
         end else begin
            last_exp.d = 8'h00;
            last_exp.v = 1'b0;
            md_fill++;
         end
         line_q.push_back(d);
         last_exp.f = LW'(md_fill);
      end
      exp_q.push_back(last_exp);
      @(posedge ap_clk);
      #1;
      shift_en = 1'b0; flush = 1'b0; len_load = 1'b0;
      if (exp_q.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk("sb_out",   32'(shift_out),  32'(e.d));
         chk("sb_valid", 32'(out_valid),  32'(e.v));
         chk("sb_fill",  32'(fill_level), 32'(e.f));
      end
   endtask

   task automatic step3(input logic en, input logic [23:0] d,
                        input logic ll = 1'b0, input logic [LW-1:0] li = '0);
      m_en = en; m_in = d; m_load = ll; m_len_in = li;
      @(posedge ap_clk);
      #1;
      m_en = 1'b0; m_load = 1'b0;
   endtask

   initial begin
      logic [7:0] in6;
      int unsigned idles;

      // reset
      #12;
      chk("rst_out",   32'(shift_out),  32'd0);
      chk("rst_valid", 32'(out_valid),  32'd0);
      chk("rst_fill",  32'(fill_level), 32'd0);
      @(negedge ap_clk);
      reset_n = 1'b1;

      // default length, 600 consecutive shifts
      for (int k = 1; k <= 600; k++) begin
         step(1'b1, 8'(k));
         if (k == 514) chk("def_valid_514", 32'(out_valid), 32'd0);
         if (k == 515) begin
            chk("def_valid_515", 32'(out_valid), 32'd1);
            chk("def_out_515",   32'(shift_out), 32'h01);
         end
      end
      chk("def_out_600",  32'(shift_out),  32'h56);
      chk("def_fill_600", 32'(fill_level), 32'd514);

      // gapped enable, len=4
      step(1'b0, 8'h00, 1'b0, 1'b1, LW'(4));
      in6 = 8'h00;
      for (int k = 1; k <= 10; k++) begin
         idles = $urandom_range(0, 2);
         for (int i = 0; i < int'(idles); i++) step(1'b0, 8'($urandom));
         step(1'b1, 8'(8'h40 + k));
         if (k == 6) in6 = 8'(8'h40 + k);
         if (k == 4) chk("gap_valid_4", 32'(out_valid), 32'd0);
         if (k == 5) chk("gap_valid_5", 32'(out_valid), 32'd1);
      end
      step(1'b0, 8'h00);
      chk("gap_out_10", 32'(shift_out), 32'(in6));

      // clamp to 1
      step(1'b0, 8'h00, 1'b0, 1'b1, LW'(0));
      step(1'b1, 8'hAA);
      chk("len1_valid_aa", 32'(out_valid), 32'd0);
      step(1'b1, 8'hBB);
      chk("len1_out_bb",   32'(shift_out), 32'hAA);
      chk("len1_valid_bb", 32'(out_valid), 32'd1);

      // clamp to DEPTH
      step(1'b0, 8'h00, 1'b0, 1'b1, LW'(1000));
      for (int k = 1; k <= 520; k++) step(1'b1, 8'(k * 3));
      chk("clamp_fill", 32'(fill_level), 32'd514);

      // flush has priority over len_load and the coincident shift
      step(1'b0, 8'h00, 1'b0, 1'b1, LW'(3));
      for (int k = 1; k <= 6; k++) step(1'b1, 8'(8'h50 + k));
      step(1'b1, 8'hEE, 1'b1, 1'b1, LW'(5));
      chk("fl_out",   32'(shift_out),  32'd0);
      chk("fl_valid", 32'(out_valid),  32'd0);
      chk("fl_fill",  32'(fill_level), 32'd0);
      for (int k = 1; k <= 4; k++) begin
         step(1'b1, 8'(8'h60 + k));
         if (k == 3) chk("fl_valid_3", 32'(out_valid), 32'd0);
      end
      chk("fl_valid_4", 32'(out_valid), 32'd1);
      chk("fl_out_4",   32'(shift_out), 32'h61);

      // async reset mid-stream
      for (int k = 1; k <= 5; k++) step(1'b1, 8'(8'h70 + k));
      shift_en = 1'b1; shift_in = 8'hCC;
      #3;
      reset_n = 1'b0;
      #1;
      chk("arst_out",   32'(shift_out),  32'd0);
      chk("arst_valid", 32'(out_valid),  32'd0);
      chk("arst_fill",  32'(fill_level), 32'd0);
      @(posedge ap_clk);
      @(negedge ap_clk);
      shift_en = 1'b0;
      reset_n = 1'b1;
      md_len = DEPTH;
      model_clear();
      exp_q.delete();
      for (int k = 1; k <= 515; k++) begin
         step(1'b1, 8'(k + 7));
         if (k == 1)   chk("arst_fill_1",   32'(fill_level), 32'd1);
         if (k == 514) chk("arst_valid_514", 32'(out_valid), 32'd0);
      end
      chk("arst_valid_515", 32'(out_valid), 32'd1);
      chk("arst_out_515",   32'(shift_out), 32'h08);

      // three channels, len=2
      step3(1'b0, 24'h0, 1'b1, LW'(2));
      for (int k = 1; k <= 5; k++) begin
         step3(1'b1, {8'(k + 8'h20), 8'(k + 8'h10), 8'(k)});
         if (k == 2) chk("mc_valid_2", 32'(m_valid), 32'd0);
         if (k == 3) chk("mc_out_3",   32'(m_out),   32'h211101);
      end
      chk("mc_out_5",   32'(m_out),   32'h231303);
      chk("mc_valid_5", 32'(m_valid), 32'd1);
      chk("mc_fill_5",  32'(m_fill),  32'd2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/bram_shift_register_mc.md
Name: bram_shift_register_mc

Overview:
- Parametrised, multi-channel, BRAM-backed delay line: successor to the fixed 514-deep, 8-bit shifter used in the HLS IP cores.
- Adds CHANNELS parallel lanes sharing one memory word.
- Adds a runtime-programmable delay length, shift enable, flush, output valid and fill-level reporting.
- Sits between HLS streaming kernels for line buffering and tap delays; one ap_clk domain.

Parameters:
- DEPTH, 514, maximum delay in shifts; memory has DEPTH words.
- DATA_W, 8, bits per channel.
- CHANNELS, 1, parallel lanes; memory word width = CHANNELS*DATA_W.
- ADDR_W, derived localparam, clog2(DEPTH); pointer width.
- LEN_W, derived localparam, clog2(DEPTH+1); length and fill width.

Ports:
- ap_clk  in  1  system clock, all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- shift_en  in  1  advance the line by one sample this cycle.
- shift_in  in  CHANNELS*DATA_W  sample in; lane c at bits [c*DATA_W +: DATA_W].
- len_in  in  LEN_W  requested delay length.
- len_load  in  1  one-cycle pulse; latches len_in.
- flush  in  1  one-cycle pulse; empties the line.
- shift_out  out  CHANNELS*DATA_W  delayed sample, registered.
- out_valid  out  1  shift_out holds a real delayed sample.
- fill_level  out  LEN_W  number of valid samples stored, 0..len.

Behaviour:
- Reset (async assert, synchronous release):
  - ptr=0, fill_level=0, len=DEPTH.
  - shift_out=0, out_valid=0.
  - Memory contents are not cleared.
- Memory: single-port read-first BRAM ring over addresses 0..len-1.
- On a shift cycle (shift_en=1, no flush, no len_load):
  - shift_out <= mem[ptr]; mem[ptr] <= shift_in.
  - ptr <= (ptr==len-1) ? 0 : ptr+1.
- Delay: the output registered on the k-th shift equals the input from shift k-len; it is visible the cycle after that shift_en.
- fill_level:
  - increments on each shift and saturates at len.
  - out_valid <= (fill_level==len) on a shift; that is, out_valid first rises on shift len+1.
- While out_valid=0, shift_out is forced to 0, so stale BRAM data never escapes.
- shift_en=0: all registers hold; shift_out and out_valid hold.
- len_load:
  - len <= clamp(len_in, 1, DEPTH); len_in=0 gives 1, len_in>DEPTH gives DEPTH.
  - Also sets ptr=0, fill_level=0, out_valid=0, shift_out=0.
  - Takes effect next cycle.
- flush: ptr=0, fill_level=0, out_valid=0, shift_out=0; len is unchanged.
- Priority: reset > flush > len_load > shift.
  - flush with len_load: the flush is applied and the new length is NOT latched.
  - A shift coincident with flush or len_load is dropped; it is not written.
- Wrap-around: ptr wraps at len-1, not at DEPTH-1; addresses len..DEPTH-1 are untouched.
- len=1: a plain one-sample register with enable; out_valid rises on the 2nd shift.
- Channels are independent bit slices; there is no cross-lane arithmetic.
- Reset mid-operation: immediate clear as above; the first post-reset shift behaves as shift 1.
- Timing: one BRAM read per shift, no combinational path from shift_in to shift_out.

Test Plan:
- Default lengths:
  - Stimulus: DEPTH=514, CHANNELS=1, reset, then 600 consecutive shifts with shift_in=k[7:0] on shift k (k from 1).
  - Required: out_valid low for shifts 1..514, rising after shift 515 with shift_out=0x01.
  - Required: after shift 600, shift_out=(600-514)&0xFF=0x56 and fill_level=514.
- Gapped enable:
  - Stimulus: len_load with len_in=4, then shifts 1..10 interleaved with random shift_en=0 idle cycles.
  - Required: output after shift 10 = input of shift 6; outputs hold during idle cycles; out_valid first rises after shift 5.
- Clamping and len=1:
  - Stimulus: len_in=0 with len_load, then shifts of 0xAA and 0xBB.
  - Required: out_valid low after the 0xAA shift; after the 0xBB shift, shift_out=0xAA and out_valid=1.
  - Stimulus: len_in=1000 with len_load.
  - Required: fill_level saturates at 514.
- Multi-channel:
  - Stimulus: CHANNELS=3, DATA_W=8, len=2, inputs {c,b,a}={k+0x20,k+0x10,k}.
  - Required: after shift 5, shift_out={0x23,0x13,0x03}.
- Flush and priority:
  - Stimulus: len=3, run 6 shifts, then flush coincident with shift_en and len_load(len_in=5).
  - Required: next cycle out_valid=0, fill_level=0, shift_out=0, len still 3.
  - Required: the following shifts need 4 shifts before out_valid rises; the coincident sample never appears.
- Async reset:
  - Stimulus: assert reset_n low mid-cycle during a shift stream.
  - Required: outputs are 0 immediately, without waiting for a clock edge; len returns to DEPTH; after release, behaviour restarts at shift 1.
